// File: rtl/pwm_modulator.sv
// PWM modulator: converts an N-bit duty level into a 1-bit pulse-width
// modulated waveform with a period of 2^N enabled ticks. The requested duty
// is double-buffered into duty_q_reg and only taken at period boundaries, so
// the output never glitches mid-period.
module pwm_modulator #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic [N-1:0] duty,
    output logic         pwm,
    output logic         period_done,
    output logic         busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [N-1:0] CNT_MAX = '1;

    state_t         state_reg, state_next;
    logic [N-1:0]   cnt_reg, cnt_next;
    logic [N-1:0]   duty_q_reg, duty_q_next;

    // State, period counter and active-duty shadow; active-low reset wins over ena
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            duty_q_reg <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            duty_q_reg <= duty_q_next;
        end
    end

    // Next-state logic: priming tick in IDLE, free-running wrap counter in RUN
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        duty_q_next = duty_q_reg;
        case (state_reg)
            IDLE: begin
                // The priming tick loads the first duty but does not count
                cnt_next = '0;
                if (ena) begin
                    duty_q_next = duty;
                    state_next  = RUN;
                end
            end
            RUN: begin
                if (ena) begin
                    // N-bit add: natural overflow provides the wrap to 0
                    cnt_next = cnt_reg + 1'b1;
                    if (cnt_reg == CNT_MAX) begin
                        duty_q_next = duty;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs decode registers only; duty input has no path to pwm
    always_comb begin
        busy        = (state_reg == RUN);
        pwm         = (state_reg == RUN) && (cnt_reg < duty_q_reg);
        period_done = (state_reg == RUN) && ena && (cnt_reg == CNT_MAX);
    end

endmodule

// File: tb/tb_pwm_modulator.sv
// Directed testbench for pwm_modulator (N=4). Inputs change on the falling
// edge; outputs are checked 1 time unit later, i.e. they reflect the register
// state left by the previous rising edge together with the current inputs.
module tb_pwm_modulator;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         ena = 1'b0;
    logic [N-1:0] duty = '0;
    logic         pwm;
    logic         period_done;
    logic         busy;

    int n_asserts  = 0;
    int n_failures = 0;

    pwm_modulator #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .duty        (duty),
        .pwm         (pwm),
        .period_done (period_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Absolute time limit so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    // One clock cycle: drive inputs, then check all three outputs
    task automatic cycle(input string tag, input bit r, input bit e, input int d,
                         input bit exp_pwm, input bit exp_pd, input bit exp_busy);
        @(negedge clk);
        rst  = r;
        ena  = e;
        duty = 4'(d);
        #1;
        n_asserts++;
        assert (pwm === exp_pwm) else begin
            n_failures++;
            $error("FAIL %s pwm: observed %b expected %b", tag, pwm, exp_pwm);
        end
        n_asserts++;
        assert (period_done === exp_pd) else begin
            n_failures++;
            $error("FAIL %s period_done: observed %b expected %b", tag, period_done, exp_pd);
        end
        n_asserts++;
        assert (busy === exp_busy) else begin
            n_failures++;
            $error("FAIL %s busy: observed %b expected %b", tag, busy, exp_busy);
        end
    endtask

    // One full 16-tick period with ena=1 and an active duty of `active`.
    // duty input is `early` for ticks below switch_k and `late` from then on;
    // the value present at tick 15 becomes the next period's duty.
    task automatic run_period(input string tag, input int active,
                              input int early, input int late, input int switch_k);
        for (int k = 0; k < 16; k++) begin
            cycle($sformatf("%s k=%0d", tag, k), 1'b1, 1'b1,
                  (k < switch_k) ? early : late,
                  (k < active), (k == 15), 1'b1);
        end
        $display("period %s: duty %0d done", tag, active);
    endtask

    initial begin
        // Reset held for two edges: everything low
        cycle("reset0", 1'b0, 1'b1, 5, 1'b0, 1'b0, 1'b0);
        cycle("reset1", 1'b0, 1'b1, 5, 1'b0, 1'b0, 1'b0);
        // Priming tick: still IDLE before the edge
        cycle("prime", 1'b1, 1'b1, 5, 1'b0, 1'b0, 1'b0);

        // Duty 5, then 3 loaded at the wrap
        run_period("d5a", 5, 5, 5, 16);
        run_period("d5b", 5, 5, 3, 15);
        // Duty 3 changed to 12 mid-period: only the wrap value matters
        run_period("d3", 3, 3, 12, 7);
        run_period("d12", 12, 12, 0, 15);
        // Duty 0 twice, with a mid-period glitch that must not take effect
        run_period("d0a", 0, 9, 0, 15);
        run_period("d0b", 0, 0, 15, 15);
        // Maximum duty: low only on the wrap tick
        run_period("d15", 15, 15, 8, 15);

        // ena toggling with duty 8: ena=0 cycles hold and never strobe,
        // and a different duty at an ena=0 wrap cycle is ignored
        for (int k = 0; k < 16; k++) begin
            cycle($sformatf("ena0 k=%0d", k), 1'b1, 1'b0, 2, (k < 8), 1'b0, 1'b1);
            cycle($sformatf("ena1 k=%0d", k), 1'b1, 1'b1, (k == 15) ? 10 : 8,
                  (k < 8), (k == 15), 1'b1);
        end
        $display("period ena-toggle: duty 8 done");

        // Duty 10, reset at cnt=9
        for (int k = 0; k < 9; k++) begin
            cycle($sformatf("d10 k=%0d", k), 1'b1, 1'b1, 10, (k < 10), 1'b0, 1'b1);
        end
        cycle("pre-reset k=9", 1'b0, 1'b1, 3, 1'b1, 1'b0, 1'b1);
        cycle("post-reset", 1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b0);
        cycle("idle-hold", 1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b0);
        cycle("reprime", 1'b1, 1'b1, 6, 1'b0, 1'b0, 1'b0);
        $display("reset mid-period: done");
        run_period("d6", 6, 6, 13, 15);

        // Triangle-like duty sequence sampled at the wraps
        run_period("tri13", 13, 13, 14, 15);
        run_period("tri14", 14, 14, 15, 15);
        run_period("tri15", 15, 15, 14, 15);
        run_period("tri14b", 14, 14, 13, 15);
        run_period("tri13b", 13, 13, 13, 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_failures);
        $finish;
    end

endmodule

// File: doc/pwm_modulator.md
Name: pwm_modulator

Overview:
- Downstream consumer of triangle_generator: takes its N-bit `out` level as `duty` and converts it into a 1-bit PWM waveform.
- Period length is 2^N `ena` ticks.
- `duty` is double-buffered, so a new value only takes effect at a period boundary and never glitches mid-period.
- Drives an LED/audio pin; `period_done` lets the upstream generator or a prescaler synchronise to PWM periods.

Parameters:
N, 4, width of duty and of the internal period counter; period = 2^N enabled clock cycles.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk)
ena  input  1  tick enable; counter and buffers advance only on cycles with ena=1
duty  input  N  requested high time in ticks per period, unsigned 0..2^N-1
pwm  output  1  modulated output
period_done  output  1  one-cycle strobe on the last tick of each period
busy  output  1  1 while in RUN state

Behaviour:
- Internal registers:
  - state: IDLE or RUN.
  - cnt[N-1:0]: period counter.
  - duty_q[N-1:0]: active duty, the shadow of `duty`.
- Reset (rst=0 at a rising edge): state=IDLE, cnt=0, duty_q=0.
  - Outputs during and after reset: pwm=0, period_done=0, busy=0.
  - Reset overrides ena and is honoured mid-period; the partial period is discarded.
- IDLE:
  - pwm=0, busy=0, cnt held at 0.
  - On the first cycle with ena=1: duty_q<=duty, cnt stays 0, state<=RUN.
  - This tick is a priming tick and does not count toward a period.
- RUN, ena=1:
  - cnt<=cnt+1, wrapping at 2^N-1 -> 0.
  - When cnt==2^N-1 (wrap tick): duty_q<=duty, sampled on that same edge. The new value governs the period starting at cnt=0.
- RUN, ena=0: cnt and duty_q hold; outputs hold their current combinational values.
- pwm is a combinational decode of registers only (no path from the duty input): pwm = (state==RUN) && (cnt < duty_q).
  - The comparison is unsigned N-bit.
  - Effect: pwm is high for exactly duty_q of the 2^N counter values.
- Duty boundaries:
  - duty_q=0: pwm never high.
  - duty_q=2^N-1: high for 2^N-1 of 2^N ticks. 100% duty is not representable by design.
- period_done = (state==RUN) && ena && (cnt==2^N-1).
  - Combinational, exactly one cycle wide, asserted on the wrap tick.
- busy = (state==RUN).
- Changes to `duty` at any time other than the wrap tick (or the IDLE priming tick) have no effect on pwm.
- No reachable state leaves RUN except reset.
- Latency:
  - A duty sampled on a wrap edge is visible on pwm in the cycle immediately after that edge, cnt=0.
  - duty_q=0 keeps pwm at 0 in that cycle.
- Width: cnt+1 is computed in N bits; natural overflow provides the wrap. No saturation logic.

Test Plan:
1. N=4, rst=0 for 2 cycles, then rst=1, ena=1 constant, duty=5 -> after the priming tick, each 16-tick period shows pwm=1 for cnt 0..4 and 0 for cnt 5..15. period_done is high once per 16 cycles, when cnt=15.
2. duty=3 during a period, then changed to 12 at cnt=7 -> the remainder of the current period follows duty 3. The period after the next wrap has 12 high ticks.
3. duty=0 for two periods, then duty=15 -> pwm is 0 for all 32 ticks, then high for 15 of 16 ticks. Low only at cnt=15, coincident with period_done.
4. ena toggled 1,0,1,0 with duty=8 -> cnt advances only on ena=1 cycles. pwm and cnt hold on ena=0 cycles. period_done fires only on a cycle with ena=1 and cnt=15.
5. Reset mid-period at cnt=9, duty_q=10 -> in the cycle after the reset edge: pwm=0, busy=0, cnt=0. The next ena primes a fresh duty_q, and counting restarts from cnt=0.
6. Chain with triangle_generator #(.N(4)) driving duty, both sharing ena -> per-period high-time sequence follows the triangle samples taken at wrap ticks. duty_q never changes outside period_done cycles.
